// File: rtl/hilo_pkg.sv
// Shared op codes, sign selects and FSM encoding for the HI/LO multiply sequencer.
// HILO_MADD_EN makes op 111 a signed multiply-accumulate instead of a NOP.
package hilo_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_MFHI  = 3'b011,
        OP_MFLO  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_MADD  = 3'b111
    } op_t;

    localparam logic [1:0] SIGN_S = 2'b10;
    localparam logic [1:0] SIGN_U = 2'b00;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic is_mul_op(input logic [2:0] op);
        logic r;
        r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef HILO_MADD_EN
        r = r || (op == OP_MADD);
`endif
        return r;
    endfunction

    // Ops that carry meaning; op 111 is inert unless MADD is built in.
    function automatic logic is_live_op(input logic [2:0] op);
        logic r;
        r = (op != OP_NOP);
`ifndef HILO_MADD_EN
        r = r && (op != OP_MADD);
`endif
        return r;
    endfunction

endpackage

// File: rtl/hilo_mult_ctrl.sv
// HI/LO register pair and multi-cycle sequencer for the external 32x32 multiplier (HILO_MADD_EN adds MADD).
// Latency: HI/LO written LATENCY cycles after the accept edge; done pulses the cycle after; MFHI/MFLO are same-cycle.
// Backpressure: stall is raised combinationally for any live op while busy; the requester holds its op.
module hilo_mult_ctrl #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [WIDTH-1:0] prod_hi,
    input  logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic [1:0]       mul_sign,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] rd_data
);
    import hilo_pkg::*;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [WIDTH-1:0]  hi_q, lo_q;
    logic              accept_mul;
    logic              last_cycle;
    logic              idle_op;

`ifdef HILO_MADD_EN
    logic              madd_q;
    logic [2*WIDTH-1:0] acc_sum;
    assign acc_sum = {hi_q, lo_q} + {prod_hi, prod_lo};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_mul) state_d = ST_BUSY;
            ST_BUSY: if (cnt_q == '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == ST_BUSY);
        stall      = start && busy && is_live_op(op);
        idle_op    = start && !busy;
        accept_mul = idle_op && is_mul_op(op);
        last_cycle = busy && (cnt_q == '0);
        rd_data    = '0;
        if (idle_op && (op == OP_MFHI)) rd_data = hi_q;
        if (idle_op && (op == OP_MFLO)) rd_data = lo_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            mul_sign <= SIGN_U;
            done     <= 1'b0;
`ifdef HILO_MADD_EN
            madd_q   <= 1'b0;
`endif
        end else begin
            done <= last_cycle;

            // Operands stay parked on the multiplier until the next accepted multiply.
            if (accept_mul) begin
                mul_a    <= rs_val;
                mul_b    <= rt_val;
                mul_sign <= (op == OP_MULTU) ? SIGN_U : SIGN_S;
                cnt_q    <= CNT_W'(LATENCY - 1);
`ifdef HILO_MADD_EN
                madd_q   <= (op == OP_MADD);
`endif
            end else if (busy && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if (last_cycle) begin
`ifdef HILO_MADD_EN
                if (madd_q) begin
                    {hi_q, lo_q} <= acc_sum;
                end else begin
                    hi_q <= prod_hi;
                    lo_q <= prod_lo;
                end
`else
                hi_q <= prod_hi;
                lo_q <= prod_lo;
`endif
            end else if (idle_op && (op == OP_MTHI)) begin
                hi_q <= rs_val;
            end else if (idle_op && (op == OP_MTLO)) begin
                lo_q <= rs_val;
            end
        end
    end

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Directed bench for hilo_mult_ctrl: attached behavioural multiplier, cycle model and literal checks.
module tb_hilo_mult_ctrl;
    localparam int LAT = 4;
`ifdef HILO_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = '0, rt_val = '0;
    logic [31:0] prod_hi, prod_lo, mul_a, mul_b, rd_data;
    logic [1:0]  mul_sign;
    logic        busy, stall, done;

    int tests = 0, fails = 0, done_seen = 0;

    always #5 clk = ~clk;

    hilo_mult_ctrl #(.WIDTH(32), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .prod_hi(prod_hi), .prod_lo(prod_lo),
        .mul_a(mul_a), .mul_b(mul_b), .mul_sign(mul_sign),
        .busy(busy), .stall(stall), .done(done), .rd_data(rd_data)
    );

    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [63:0] xa, xb;
        xa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        xb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return xa * xb;
    endfunction

    // Combinational multiplier attached beside the block.
    always_comb {prod_hi, prod_lo} = mul64(mul_a, mul_b, mul_sign == 2'b10);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural HI/LO, parked operands, remaining busy cycles.
    logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
    logic [1:0]  m_sign = '0;
    logic [63:0] m_p;
    int          m_left = 0;
    bit          m_done = 1'b0, m_madd = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_a = '0; m_b = '0; m_sign = '0;
            m_left = 0; m_done = 1'b0; m_madd = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_p = mul64(m_a, m_b, m_sign == 2'b10);
                    if (m_madd) {m_hi, m_lo} = {m_hi, m_lo} + m_p;
                    else        {m_hi, m_lo} = m_p;
                    m_done = 1'b1;
                end
            end else if (start) begin
                if (op == 3'd1 || op == 3'd2 || (op == 3'd7 && MADD)) begin
                    m_a = rs_val; m_b = rt_val;
                    m_sign = (op == 3'd2) ? 2'b00 : 2'b10;
                    m_madd = (op == 3'd7);
                    m_left = LAT;
                end else if (op == 3'd5) begin
                    m_hi = rs_val;
                end else if (op == 3'd6) begin
                    m_lo = rs_val;
                end
            end
        end
    end

    logic        e_busy, e_stall;
    logic [31:0] e_rd;
    always @(negedge clk) begin
        e_busy  = (m_left > 0);
        e_stall = start && e_busy && op != 3'd0 && !(op == 3'd7 && !MADD);
        e_rd    = '0;
        if (start && !e_busy && op == 3'd3) e_rd = m_hi;
        if (start && !e_busy && op == 3'd4) e_rd = m_lo;
        chk("busy", busy, e_busy);
        chk("stall", stall, e_stall);
        chk("done", done, m_done);
        chk("rd_data", rd_data, e_rd);
        chk("mul_a", mul_a, m_a);
        chk("mul_b", mul_b, m_b);
        chk("mul_sign", mul_sign, m_sign);
        if (done === 1'b1) done_seen++;
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] rs, input logic [31:0] rt);
        start = 1'b1; op = o; rs_val = rs; rt_val = rt;
        cyc();
        start = 1'b0; op = 3'd0;
    endtask

    task automatic read_chk(input logic [2:0] o, input logic [31:0] exp, input string name);
        start = 1'b1; op = o;
        @(negedge clk);
        chk(name, rd_data, exp);
        cyc();
        start = 1'b0; op = 3'd0;
    endtask

    task automatic hold_op(input logic [2:0] o, input logic [31:0] rs, output int nstall, output logic [31:0] rd);
        bit ok;
        ok = 1'b0; nstall = 0; rd = '0;
        start = 1'b1; op = o; rs_val = rs; rt_val = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall !== 1'b1) begin ok = 1'b1; rd = rd_data; break; end
            nstall++;
            cyc();
        end
        if (!ok) chk("hold_timeout", 64'd1, 64'd0);
        cyc();
        start = 1'b0; op = 3'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin cyc(); n++; end
        if (n >= 50) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    int          n, ns;
    logic [31:0] rd;

    initial begin
        repeat (3) cyc();
        chk("reset_busy", busy, 1'b0);
        chk("reset_mul_a", mul_a, 32'h0);
        chk("reset_done", done, 1'b0);
        reset = 1'b0;
        read_chk(3'd3, 32'h0, "reset_hi");

        // MULT -3 * 5
        issue(3'd1, 32'hFFFFFFFD, 32'd5);
        chk("mult_sign", mul_sign, 2'b10);
        chk("mult_a", mul_a, 32'hFFFFFFFD);
        wait_idle(n);
        chk("mult_busy_cycles", n, 4);
        chk("mult_done", done, 1'b1);
        read_chk(3'd3, 32'hFFFFFFFF, "mult_hi");
        read_chk(3'd4, 32'hFFFFFFF1, "mult_lo");

        // MULTU FFFFFFFF * 2
        issue(3'd2, 32'hFFFFFFFF, 32'd2);
        chk("multu_sign", mul_sign, 2'b00);
        wait_idle(n);
        read_chk(3'd3, 32'h00000001, "multu_hi");
        read_chk(3'd4, 32'hFFFFFFFE, "multu_lo");

        // MFLO held behind a MULT
        issue(3'd1, 32'd7, 32'd6);
        hold_op(3'd4, 32'h0, ns, rd);
        chk("mflo_stalls", ns, 4);
        chk("mflo_after_mult", rd, 32'd42);

        // MTHI then MFHI
        issue(3'd5, 32'h12345678, 32'h0);
        read_chk(3'd3, 32'h12345678, "mthi_mfhi");

        // MTLO held behind a MULT
        issue(3'd1, 32'd3, 32'd4);
        hold_op(3'd6, 32'hAABBCCDD, ns, rd);
        chk("mtlo_stalls", ns, 4);
        read_chk(3'd4, 32'hAABBCCDD, "mtlo_lo");
        read_chk(3'd3, 32'h0, "mtlo_hi");

        // Reset while cnt==2 aborts the multiply
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("abort_busy", busy, 1'b0);
        read_chk(3'd3, 32'h0, "abort_hi");
        read_chk(3'd4, 32'h0, "abort_lo");
        issue(3'd1, 32'd2, 32'd3);
        chk("post_reset_busy", busy, 1'b1);
        wait_idle(n);
        read_chk(3'd4, 32'd6, "post_reset_lo");

        // op 111 while busy
        issue(3'd1, 32'd5, 32'd5);
        start = 1'b1; op = 3'd7;
        @(negedge clk);
        chk("op7_busy_stall", stall, MADD);
        cyc();
        start = 1'b0; op = 3'd0;
        wait_idle(n);

        // HI:LO = 0:FFFFFFFF, op 111 with 1*1
        issue(3'd5, 32'h0, 32'h0);
        issue(3'd6, 32'hFFFFFFFF, 32'h0);
        issue(3'd7, 32'd1, 32'd1);
        wait_idle(n);
        read_chk(3'd3, MADD ? 32'h1 : 32'h0, "madd_hi");
        read_chk(3'd4, MADD ? 32'h0 : 32'hFFFFFFFF, "madd_lo");

        repeat (3) cyc();
        chk("done_count", done_seen, MADD ? 7 : 6);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
